huffman_dc_dec: RTL

//  Bit-serial JPEG baseline DC Huffman decoder, the inverse of the DC entropy encoder.

---
 rtl/huffman_dc_dec.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/huffman_dc_dec.sv
// Bit-serial JPEG baseline DC Huffman decoder: category code then SIZE amplitude bits.
// Optional HUFF_DC_PRED_EN adds per-component DC predictors so dc_out is absolute DC.
module huffman_dc_dec #(
    parameter int unsigned DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          is_luminance,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    size_out,
    output logic [DW-1:0] dc_out,
    output logic          err
`ifdef HUFF_DC_PRED_EN
    ,
    input  logic          pred_clr,
    input  logic [1:0]    comp_id
`endif
);

    typedef enum logic [1:0] {StCode, StAmp, StOut, StErr} state_e;

    state_e        state_q, state_d;
    logic [9:0]    code_q, code_d;   // previous bits only; the newest bit comes from bit_in
    logic [3:0]    len_q, len_d;
    logic          luma_q, luma_d;
    logic [9:0]    amp_q, amp_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    size_q, size_d;
    logic [DW-1:0] dc_q, dc_d;

    logic [10:0]   new_code;
    logic [3:0]    new_len;
    logic          luma_sel;
    logic          hit;
    logic [3:0]    hit_size;
    logic          no_match_end;
    logic [10:0]   new_amp;
    logic [DW-1:0] amp_ext;
    logic [DW-1:0] amp_mask;
    logic [DW-1:0] diff;
    logic [DW-1:0] pred_base;

    // Returns {hit, size} for a code of length len (code right-aligned, upper bits zero).
    function automatic logic [4:0] lookup(input logic luma, input logic [10:0] code,
                                          input logic [3:0] len);
        logic       h;
        logic [3:0] s;
        h = 1'b0;
        s = 4'd0;
        if (luma) begin
            if (len == 4'd2 && code == 11'd0) begin
                h = 1'b1;
            end else if (len == 4'd3 && code >= 11'd2 && code <= 11'd6) begin
                h = 1'b1;
                s = 4'(code) - 4'd1;
            end else if (len >= 4'd4 && len <= 4'd9 && code == (11'd1 << len) - 11'd2) begin
                h = 1'b1;
                s = len + 4'd2;
            end
        end else begin
            if (len == 4'd2 && code != 11'd3) begin
                h = 1'b1;
                s = 4'(code);
            end else if (len >= 4'd3 && code == (11'd1 << len) - 11'd2) begin
                h = 1'b1;
                s = len;
            end
        end
        return {h, s};
    endfunction

`ifdef HUFF_DC_PRED_EN
    logic [1:0]    comp_q, comp_d;
    logic [DW-1:0] pred_q [3];
    logic [DW-1:0] pred_d [3];

    assign pred_base = (comp_q == 2'd3) ? '0 : pred_q[comp_q];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pred_d[i] = pred_q[i];
        end
        // Restart clear beats a same-cycle update; error symbols never touch predictors.
        if (pred_clr) begin
            for (int i = 0; i < 3; i++) begin
                pred_d[i] = '0;
            end
        end else if (state_q == StOut && out_ready && comp_q != 2'd3) begin
            pred_d[comp_q] = dc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_q <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            comp_q <= comp_d;
            for (int i = 0; i < 3; i++) begin
                pred_q[i] <= pred_d[i];
            end
        end
    end
`else
    assign pred_base = '0;
`endif

    assign new_code     = {code_q, bit_in};
    assign new_len      = len_q + 4'd1;
    assign luma_sel     = (len_q == 4'd0) ? is_luminance : luma_q;
    assign {hit, hit_size} = lookup(luma_sel, new_code, new_len);
    assign no_match_end = (luma_sel && new_len == 4'd9) || (!luma_sel && new_len == 4'd11);

    // Negative amplitudes are stored one's-complement style: value = amp - (2^SIZE - 1).
    assign new_amp  = {amp_q, bit_in};
    assign amp_ext  = {{(DW-11){1'b0}}, new_amp};
    assign amp_mask = (DW'(1) << size_q) - DW'(1);
    assign diff     = new_amp[size_q - 4'd1] ? amp_ext : amp_ext - amp_mask;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        luma_d  = luma_q;
        amp_d   = amp_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        dc_d    = dc_q;
`ifdef HUFF_DC_PRED_EN
        comp_d  = comp_q;
`endif
        unique case (state_q)
            StCode: begin
                if (bit_valid) begin
                    code_d = new_code[9:0];
                    len_d  = new_len;
                    luma_d = luma_sel;
`ifdef HUFF_DC_PRED_EN
                    if (len_q == 4'd0) begin
                        comp_d = comp_id;
                    end
`endif
                    if (hit) begin
                        size_d = hit_size;
                        if (hit_size == 4'd0) begin
                            dc_d    = pred_base;
                            state_d = StOut;
                        end else begin
                            cnt_d   = hit_size;
                            state_d = StAmp;
                        end
                    end else if (no_match_end) begin
                        size_d  = 4'd0;
                        dc_d    = '0;
                        state_d = StErr;
                    end
                end
            end
            StAmp: begin
                if (bit_valid) begin
                    amp_d = new_amp[9:0];
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        dc_d    = pred_base + diff;
                        state_d = StOut;
                    end
                end
            end
            StOut, StErr: begin
                if (out_ready) begin
                    code_d  = '0;
                    len_d   = 4'd0;
                    amp_d   = '0;
                    cnt_d   = 4'd0;
                    size_d  = 4'd0;
                    dc_d    = '0;
                    state_d = StCode;
                end
            end
            default: state_d = StCode;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCode;
            code_q  <= '0;
            len_q   <= 4'd0;
            luma_q  <= 1'b0;
            amp_q   <= '0;
            cnt_q   <= 4'd0;
            size_q  <= 4'd0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            luma_q  <= luma_d;
            amp_q   <= amp_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            dc_q    <= dc_d;
        end
    end

    assign bit_ready = (state_q == StCode) || (state_q == StAmp);
    assign out_valid = (state_q == StOut) || (state_q == StErr);
    assign err       = (state_q == StErr);
    assign size_out  = size_q;
    assign dc_out    = dc_q;

endmodule
